bmc_pwr_dn_seq: RTL and testbench
=================================

// Module: bmc_pwr_dn_seq
// PURPOSE
//  Orderly power-down sequencer for the BMC AUX rails; the shutdown counterpart of the BMC power-up sequencing.
//  On SLP_SUS# assertion or a fault request, it holds BMC SRST# low for a fixed time.
//  It then withdraws the P2V5 enable permission and waits for P1V1 PWRGD to discharge, with a timeout.
//  Its outputs gate the up-sequencer: oP2v5EnAllow is ANDed into the P2V5 enable; oSrstHold_n is ANDed into RST_SRST_BMC_N.
// PARAMETERS
//  SRST_HOLD_MS     2   ms that SRST# is held low before the VR enable is dropped (1..31)
//  DISCHARGE_TO_MS  20  ms allowed for PWRGD_P1V1_BMC_AUX to fall after enable removal (1..31)
//  CNT_W            5   width of the ms down-counter; must hold max(SRST_HOLD_MS, DISCHARGE_TO_MS)
// PORTS
//  iClk          in   1  system clock
//  iRst_n        in   1  asynchronous active-low reset
//  i1mSCE        in   1  1 ms clock-enable strobe, one iClk wide
//  iSlpSus_n     in   1  FM_SLP_SUS_N, asynchronous; 2-FF synchronised internally
//  iBmcPwrgd     in   1  PWRGD_P1V1_BMC_AUX (last BMC rail), synchronous
//  iFltReq       in   1  emergency power-down request (BMC/PCH VR fault), synchronous, level
//  iGoOutFltSt   in   1  clears the timeout fault state, single-cycle pulse
//  oP2v5EnAllow  out  1  1 = up-sequencer may drive FM_BMC_P2V5_AUX_EN
//  oSrstHold_n   out  1  0 = force RST_SRST_BMC_N low
//  oPwrDnDone    out  1  1 = rails confirmed off (OFF state)
//  oDischargeTo  out  1  sticky: PWRGD did not fall within DISCHARGE_TO_MS
//  ovState       out  3  current FSM encoding, for debug/SMBus mailbox
// BEHAVIOUR
//  Reset values: oP2v5EnAllow=0, oSrstHold_n=0, oPwrDnDone=1, oDischargeTo=0, ovState=OFF. Sync FFs reset to 0.
//  All outputs are registered and decoded from the state register; they update the cycle after the state changes.
//  States: OFF=0, ON=1, SRST=2, VR_OFF=3, WAIT_DIS=4, TO_FLT=5; codes 6 and 7 recover to OFF.
//  OFF:      allow=0, hold_n=0, done=1.
//            -> ON when synced SlpSus_n=1 and iFltReq=0 and iBmcPwrgd=0.
//            iFltReq has priority over the power-up request; OFF is held while iFltReq=1.
//  ON:       allow=1, hold_n=1, done=0.
//            -> SRST on power-down trigger (synced SlpSus_n=0, or iFltReq=1). Counter loads SRST_HOLD_MS.
//  SRST:     allow=1, hold_n=0.
//            Counter decrements on each i1mSCE; at count==0 with i1mSCE -> VR_OFF.
//            Hold time lies between SRST_HOLD_MS-1 and SRST_HOLD_MS ms (strobe granularity).
//  VR_OFF:   allow=0, hold_n=0. Lasts exactly one iClk.
//            Loads DISCHARGE_TO_MS into the counter; -> WAIT_DIS.
//  WAIT_DIS: allow=0, hold_n=0.
//            iBmcPwrgd=0 -> OFF (checked before timeout; a same-cycle tie goes to OFF).
//            Counter==0 with i1mSCE -> TO_FLT, and sets oDischargeTo.
//  TO_FLT:   allow=0, hold_n=0, done=0.
//            iGoOutFltSt -> OFF and clears oDischargeTo, only if iBmcPwrgd=0; otherwise the pulse is ignored.
//  SlpSus_n rising during SRST, VR_OFF or WAIT_DIS is ignored.
//  The sequence always completes to OFF, then re-powers from OFF.
//  iFltReq asserting during SRST or WAIT_DIS does not restart the counter.
//  iGoOutFltSt in any state other than TO_FLT has no effect.
//  Counter: CNT_W-bit unsigned down-counter; it saturates at 0 and never wraps.
//  Async reset mid-sequence forces OFF immediately.
//  OFF is safe: enable is removed and SRST is asserted.
// CONFIGURATION
//  `define BMC_PWRDN_DEBOUNCE_EN:
//    SlpSus_n=0 must be seen on two consecutive i1mSCE strobes before ON -> SRST (1-2 ms filter).
//    A glitch shorter than that leaves the block in ON.
//    iFltReq always bypasses the filter.
//  Without the macro: ON -> SRST occurs on the cycle after the synchronised SlpSus_n is seen low (3-cycle latency from the pin).
// TESTING
//  1. Reset released, SlpSus_n=1, Pwrgd=0 -> OFF to ON within 3 clks; allow=1, hold_n=1, done=0.
//  2. ON, SlpSus_n falls -> hold_n=0 at once; allow drops after the 2nd i1mSCE.
//     Pwrgd falls 3 ms later -> OFF, done=1, DischargeTo=0.
//  3. ON, then drop allow while Pwrgd stays 1 -> after 20 strobes: TO_FLT, DischargeTo=1.
//     iGoOutFltSt with Pwrgd=1 -> stays TO_FLT; with Pwrgd=0 -> OFF, flag cleared.
//  4. Force a tie in WAIT_DIS (Pwrgd falls on the cycle count==0 and i1mSCE=1) -> OFF, no timeout.
//  5. iFltReq=1 in OFF with SlpSus_n=1 -> remains OFF.
//     In ON, iFltReq pulse -> full sequence runs; SlpSus_n toggling mid-sequence is ignored.
//  6. Debounce build: 0.5 ms SlpSus_n low glitch -> stays ON; 3 ms low -> SRST.
//     Non-debounce build: same glitch -> SRST. Async reset in WAIT_DIS -> OFF, all outputs at reset values.

Source files
------------

// File: rtl/bmc_pwr_dn_seq.sv
// Orderly power-down sequencer for the BMC AUX rails: SRST hold, P2V5 enable removal, P1V1 discharge wait.
// Optional build macro BMC_PWRDN_DEBOUNCE_EN adds a two-strobe filter on SLP_SUS# before ON -> SRST.
module bmc_pwr_dn_seq #(
  parameter int SRST_HOLD_MS    = 2,
  parameter int DISCHARGE_TO_MS = 20,
  parameter int CNT_W           = 5
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       i1mSCE,
  input  logic       iSlpSus_n,
  input  logic       iBmcPwrgd,
  input  logic       iFltReq,
  input  logic       iGoOutFltSt,
  output logic       oP2v5EnAllow,
  output logic       oSrstHold_n,
  output logic       oPwrDnDone,
  output logic       oDischargeTo,
  output logic [2:0] ovState
);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_ON       = 3'd1,
    ST_SRST     = 3'd2,
    ST_VR_OFF   = 3'd3,
    ST_WAIT_DIS = 3'd4,
    ST_TO_FLT   = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(SRST_HOLD_MS);
  localparam logic [CNT_W-1:0] DIS_LD  = CNT_W'(DISCHARGE_TO_MS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             slp_meta_q;
  logic             slp_sync_q;
  logic             allow_q;
  logic             hold_n_q;
  logic             done_q;
  logic             dis_to_q;
`ifdef BMC_PWRDN_DEBOUNCE_EN
  logic             deb_q;
`endif

  // Saturating decrement; the timed states leave on the strobe that brings the count to zero.
  assign cnt_d = (cnt_q == '0) ? '0 : cnt_q - ONE;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q    <= ST_OFF;
      cnt_q      <= '0;
      slp_meta_q <= 1'b0;
      slp_sync_q <= 1'b0;
      allow_q    <= 1'b0;
      hold_n_q   <= 1'b0;
      done_q     <= 1'b1;
      dis_to_q   <= 1'b0;
`ifdef BMC_PWRDN_DEBOUNCE_EN
      deb_q      <= 1'b0;
`endif
    end else begin
      slp_meta_q <= iSlpSus_n;
      slp_sync_q <= slp_meta_q;
      // Outputs follow the state register one cycle later.
      allow_q    <= (state_q == ST_ON) || (state_q == ST_SRST);
      hold_n_q   <= (state_q == ST_ON);
      done_q     <= (state_q == ST_OFF);
      dis_to_q   <= (state_q == ST_TO_FLT);
      case (state_q)
        ST_OFF: begin
`ifdef BMC_PWRDN_DEBOUNCE_EN
          deb_q <= 1'b0;
`endif
          if (slp_sync_q && !iFltReq && !iBmcPwrgd) state_q <= ST_ON;
        end
        ST_ON: begin
`ifdef BMC_PWRDN_DEBOUNCE_EN
          if (iFltReq) begin
            state_q <= ST_SRST;
            cnt_q   <= HOLD_LD;
          end else if (slp_sync_q) begin
            deb_q <= 1'b0;
          end else if (i1mSCE) begin
            if (deb_q) begin
              state_q <= ST_SRST;
              cnt_q   <= HOLD_LD;
            end else begin
              deb_q <= 1'b1;
            end
          end
`else
          if (iFltReq || !slp_sync_q) begin
            state_q <= ST_SRST;
            cnt_q   <= HOLD_LD;
          end
`endif
        end
        ST_SRST: begin
          if (i1mSCE) begin
            cnt_q <= cnt_d;
            if (cnt_q <= ONE) state_q <= ST_VR_OFF;
          end
        end
        ST_VR_OFF: begin
          cnt_q   <= DIS_LD;
          state_q <= ST_WAIT_DIS;
        end
        ST_WAIT_DIS: begin
          if (!iBmcPwrgd) begin
            state_q <= ST_OFF;
          end else if (i1mSCE) begin
            cnt_q <= cnt_d;
            if (cnt_q <= ONE) state_q <= ST_TO_FLT;
          end
        end
        ST_TO_FLT: begin
          if (iGoOutFltSt && !iBmcPwrgd) state_q <= ST_OFF;
        end
        default: state_q <= ST_OFF;
      endcase
    end
  end

  assign oP2v5EnAllow = allow_q;
  assign oSrstHold_n  = hold_n_q;
  assign oPwrDnDone   = done_q;
  assign oDischargeTo = dis_to_q;
  assign ovState      = state_q;

endmodule

// File: tb/tb_bmc_pwr_dn_seq.sv
// Self-checking bench for bmc_pwr_dn_seq: directed sequence with randomized strobe gaps and discharge times.
module tb_bmc_pwr_dn_seq;

  localparam int HOLD_MS = 2;
  localparam int TO_MS   = 20;
  localparam logic [2:0] S_OFF = 3'd0, S_ON = 3'd1, S_SRST = 3'd2,
                         S_VR_OFF = 3'd3, S_WAIT = 3'd4, S_TO = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sce = 1'b0;
  logic       slp_n = 1'b1;
  logic       pwrgd = 1'b0;
  logic       flt = 1'b0;
  logic       go_out = 1'b0;
  logic       allow, hold_n, done, dis_to;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;
  logic [2:0] exp_q[$];

  bmc_pwr_dn_seq #(.SRST_HOLD_MS(HOLD_MS), .DISCHARGE_TO_MS(TO_MS), .CNT_W(5)) dut (
    .iClk(clk), .iRst_n(rst_n), .i1mSCE(sce), .iSlpSus_n(slp_n), .iBmcPwrgd(pwrgd),
    .iFltReq(flt), .iGoOutFltSt(go_out), .oP2v5EnAllow(allow), .oSrstHold_n(hold_n),
    .oPwrDnDone(done), .oDischargeTo(dis_to), .ovState(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Phase -> {allow, hold_n, done} as the externally visible contract.
  function automatic logic [2:0] phase_outs(input logic [2:0] ph);
    case (ph)
      S_OFF:   return 3'b001;
      S_ON:    return 3'b110;
      S_SRST:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk_outs(input string tag, input logic [2:0] ph);
    logic [2:0] e;
    e = phase_outs(ph);
    chk({tag, "_allow"}, 8'(allow), 8'(e[2]));
    chk({tag, "_hold_n"}, 8'(hold_n), 8'(e[1]));
    chk({tag, "_done"}, 8'(done), 8'(e[0]));
  endtask

  task automatic wait_state(input string tag, input logic [2:0] expv, input int budget);
    int n = 0;
    while (state !== expv && n < budget) begin
      step();
      n++;
    end
    chk(tag, 8'(state), 8'(expv));
  endtask

  task automatic strobe_gap(input int gap);
    repeat (gap) step();
    sce = 1'b1;
    step();
    sce = 1'b0;
  endtask

  task automatic strobe();
    strobe_gap($urandom_range(1, 4));
  endtask

  task automatic pulse_go();
    go_out = 1'b1;
    step();
    go_out = 1'b0;
  endtask

  // Drop SLP_SUS# from ON and confirm entry to SRST, then check the SRST outputs.
  task automatic power_down_slp();
    pwrgd = 1'b1;
    slp_n = 1'b0;
`ifdef BMC_PWRDN_DEBOUNCE_EN
    strobe_gap($urandom_range(3, 6));
    chk("deb_first_strobe_on", 8'(state), 8'(S_ON));
    strobe();
    chk("deb_second_strobe_srst", 8'(state), 8'(S_SRST));
`else
    step();
    step();
    chk("slp_lat2_on", 8'(state), 8'(S_ON));
    step();
    chk("slp_lat3_srst", 8'(state), 8'(S_SRST));
`endif
    step();
    chk_outs("srst", S_SRST);
  endtask

  // SRST ends on the HOLD_MS-th strobe; one VR_OFF cycle follows.
  task automatic run_srst();
    for (int i = 1; i < HOLD_MS; i++) begin
      strobe();
      chk("srst_mid", 8'(state), 8'(S_SRST));
    end
    strobe();
    chk("srst_end_vr_off", 8'(state), 8'(S_VR_OFF));
    step();
    chk("vr_off_one_clk", 8'(state), 8'(S_WAIT));
    chk("allow_dropped", 8'(allow), 8'(0));
  endtask

  // Model: PWRGD falling after k strobes beats the timeout only if k < TO_MS.
  task automatic run_wait(input int k);
    logic [2:0] got;
    int n;
    exp_q.push_back((k >= TO_MS) ? S_TO : S_OFF);
    n = (k >= TO_MS) ? TO_MS : k;
    for (int i = 0; i < n; i++) strobe();
    if (k < TO_MS) begin
      pwrgd = 1'b0;
      step();
    end
    got = state;
    chk("wait_outcome", 8'(got), 8'(exp_q.pop_front()));
    step();
    chk("dis_to_flag", 8'(dis_to), 8'(got == S_TO));
    chk("done_flag", 8'(done), 8'(got == S_OFF));
    if (got == S_TO) begin
      pwrgd = 1'b0;
      pulse_go();
      chk("to_recover", 8'(state), 8'(S_OFF));
      step();
    end
  endtask

  initial begin
    // Reset values
    repeat (3) step();
    chk("rst_state", 8'(state), 8'(S_OFF));
    chk("rst_dis_to", 8'(dis_to), 8'(0));
    chk_outs("rst", S_OFF);

    // Power-up from OFF within three clocks of reset release
    rst_n = 1'b1;
    step();
    step();
    chk("pu_lat2_off", 8'(state), 8'(S_OFF));
    step();
    chk("pu_lat3_on", 8'(state), 8'(S_ON));
    step();
    chk_outs("on", S_ON);
    pulse_go();
    chk("go_in_on_ignored", 8'(state), 8'(S_ON));

    // Normal power-down: PWRGD falls three strobes into WAIT_DIS
    power_down_slp();
    run_srst();
    slp_n = 1'b1;
    run_wait(3);
    wait_state("repower_1", S_ON, 5);

    // Discharge timeout, fault exit gated by PWRGD
    power_down_slp();
    run_srst();
    slp_n = 1'b1;
    for (int i = 0; i < TO_MS - 1; i++) strobe();
    chk("to_19_still_wait", 8'(state), 8'(S_WAIT));
    strobe();
    chk("to_20_flt", 8'(state), 8'(S_TO));
    step();
    chk("to_flag_set", 8'(dis_to), 8'(1));
    chk_outs("to_flt", S_TO);
    pulse_go();
    chk("go_pwrgd_hi_ignored", 8'(state), 8'(S_TO));
    pwrgd = 1'b0;
    step();
    step();
    chk("pwrgd_lo_no_go_stays", 8'(state), 8'(S_TO));
    pulse_go();
    chk("go_pwrgd_lo_off", 8'(state), 8'(S_OFF));
    step();
    chk("to_flag_cleared", 8'(dis_to), 8'(0));
    chk("to_exit_done", 8'(done), 8'(1));
    wait_state("repower_2", S_ON, 5);

    // Tie: PWRGD falls on the timeout strobe -> OFF; iFltReq then holds OFF
    power_down_slp();
    run_srst();
    slp_n = 1'b1;
    for (int i = 0; i < TO_MS - 1; i++) strobe();
    step();
    sce = 1'b1;
    pwrgd = 1'b0;
    flt = 1'b1;
    step();
    sce = 1'b0;
    chk("tie_off", 8'(state), 8'(S_OFF));
    step();
    chk("tie_no_flag", 8'(dis_to), 8'(0));
    repeat ($urandom_range(2, 10)) step();
    chk("flt_holds_off", 8'(state), 8'(S_OFF));
    flt = 1'b0;
    step();
    chk("flt_release_on", 8'(state), 8'(S_ON));

    // Fault pulse in ON runs the full sequence; SLP toggles and a re-asserted fault are ignored
    pwrgd = 1'b1;
    step();
    flt = 1'b1;
    step();
    flt = 1'b0;
    chk("flt_pulse_srst", 8'(state), 8'(S_SRST));
    slp_n = 1'b0;
    strobe();
    chk("flt_seq_srst_mid", 8'(state), 8'(S_SRST));
    flt = 1'b1;
    slp_n = 1'b1;
    strobe();
    chk("flt_no_restart", 8'(state), 8'(S_VR_OFF));
    flt = 1'b0;
    step();
    slp_n = 1'b0;
    step();
    step();
    slp_n = 1'b1;
    chk("slp_toggle_ignored", 8'(state), 8'(S_WAIT));
    run_wait($urandom_range(0, TO_MS - 1));
    wait_state("repower_3", S_ON, 5);

    // Short SLP_SUS# glitch with no strobe inside it
    pwrgd = 1'b1;
    slp_n = 1'b0;
    repeat (5) step();
    slp_n = 1'b1;
    repeat (4) step();
`ifdef BMC_PWRDN_DEBOUNCE_EN
    chk("glitch_filtered", 8'(state), 8'(S_ON));
    power_down_slp();
`else
    chk("glitch_trips", 8'(state), 8'(S_SRST));
`endif
    run_srst();
    slp_n = 1'b1;
    run_wait($urandom_range(0, TO_MS + 4));
    wait_state("repower_4", S_ON, 5);

    // Randomized discharge times around the timeout boundary
    for (int r = 0; r < 4; r++) begin
      power_down_slp();
      run_srst();
      slp_n = 1'b1;
      run_wait($urandom_range(TO_MS - 3, TO_MS + 2));
      wait_state("repower_rand", S_ON, 5);
    end

    // Async reset in WAIT_DIS
    power_down_slp();
    run_srst();
    repeat ($urandom_range(1, 5)) strobe();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 8'(state), 8'(S_OFF));
    chk("async_rst_flag", 8'(dis_to), 8'(0));
    chk_outs("async_rst", S_OFF);
    step();
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
